// File: rtl/tcdm_bfly_prio_ctrl.sv
// Layer-priority scheduler for the radix-2 butterfly TCDM interconnect.
// Base priority comes from a round-robin counter or an LFSR; a starvation monitor can override it.
module tcdm_bfly_prio_ctrl #(
    parameter int unsigned  NumIn     = 8,
    parameter int unsigned  StarveThr = 15,
    parameter logic [15:0]  LfsrSeed  = 16'hACE1,
    localparam int unsigned NumLayers = $clog2(NumIn)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic                 mode_i,
    input  logic [NumIn-1:0]     req_i,
    input  logic [NumIn-1:0]     gnt_i,
    output logic [NumLayers-1:0] prio_o,
    output logic                 boost_o,
    output logic [NumLayers-1:0] boost_idx_o,
    output logic [15:0]          boost_cnt_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        BOOST = 1'b1
    } state_e;

    localparam logic [7:0] Thr = 8'(StarveThr);

    state_e               state_q, state_d;
    logic [NumLayers-1:0] cnt_q, cnt_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [7:0]           wait_q [NumIn];
    logic [7:0]           wait_d [NumIn];
    logic [NumLayers-1:0] boost_idx_q, boost_idx_d;
    logic [15:0]          boost_cnt_q, boost_cnt_d;

    logic                 adv;
    logic [NumIn-1:0]     stall;
    logic                 starve_vld;
    logic [NumLayers-1:0] starve_idx;
    logic [NumLayers-1:0] lfsr_base;
    logic [NumLayers-1:0] base;

    assign adv   = en_i & |(req_i & gnt_i);
    assign stall = req_i & ~gnt_i & {NumIn{en_i}};

    // Wide networks see the 16-bit LFSR zero-extended into the upper layers.
    if (NumLayers <= 16) begin : g_lfsr_narrow
        assign lfsr_base = lfsr_q[NumLayers-1:0];
    end else begin : g_lfsr_wide
        assign lfsr_base = {{(NumLayers-16){1'b0}}, lfsr_q};
    end

    assign base = mode_i ? lfsr_base : cnt_q;

    // NOTE: every variable gets its default at the top of the block so no path leaves it unassigned (no latches).
    always_comb begin
        cnt_d  = cnt_q;
        lfsr_d = lfsr_q;
        if (adv) begin
            cnt_d  = cnt_q + 1'b1;
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
        end

        for (int i = 0; i < NumIn; i++) begin
            wait_d[i] = 8'd0;
            if (stall[i]) begin
                wait_d[i] = (wait_q[i] == Thr) ? Thr : wait_q[i] + 8'd1;
            end
        end

        // Scan downwards so the lowest starving initiator wins.
        starve_vld = 1'b0;
        starve_idx = '0;
        for (int i = NumIn - 1; i >= 0; i--) begin
            if (stall[i] && (wait_q[i] == Thr)) begin
                starve_vld = 1'b1;
                starve_idx = NumLayers'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        boost_idx_d = boost_idx_q;
        boost_cnt_d = boost_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (starve_vld) begin
                    state_d     = BOOST;
                    boost_idx_d = starve_idx;
                    if (boost_cnt_q != 16'hFFFF) begin
                        boost_cnt_d = boost_cnt_q + 16'd1;
                    end
                end
            end
            BOOST: begin
                if (gnt_i[boost_idx_q] || !req_i[boost_idx_q] || !en_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the wait counters are individual flops, so they take part in the async reset like any other state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            lfsr_q      <= LfsrSeed;
            boost_idx_q <= '0;
            boost_cnt_q <= '0;
            for (int i = 0; i < NumIn; i++) begin
                wait_q[i] <= 8'd0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lfsr_q      <= lfsr_d;
            boost_idx_q <= boost_idx_d;
            boost_cnt_q <= boost_cnt_d;
            for (int i = 0; i < NumIn; i++) begin
                wait_q[i] <= wait_d[i];
            end
        end
    end

    assign boost_o     = (state_q == BOOST);
    assign boost_idx_o = boost_idx_q;
    assign boost_cnt_o = boost_cnt_q;
    // While boosted, every layer routes the boosted initiator's input bit through.
    assign prio_o      = boost_o ? boost_idx_q : base;

endmodule

// File: tb/tb_tcdm_bfly_prio_ctrl.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized run
// compared every cycle against a behavioural scheduler model.
module tb_tcdm_bfly_prio_ctrl;

    localparam int N   = 8;
    localparam int THR = 3;

    logic         clk_i;
    logic         rst_ni;
    logic         en_i;
    logic         mode_i;
    logic [N-1:0] req_i;
    logic [N-1:0] gnt_i;
    logic [2:0]   prio_o;
    logic         boost_o;
    logic [2:0]   boost_idx_o;
    logic [15:0]  boost_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    tcdm_bfly_prio_ctrl #(
        .NumIn     (N),
        .StarveThr (THR),
        .LfsrSeed  (16'hACE1)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .mode_i      (mode_i),
        .req_i       (req_i),
        .gnt_i       (gnt_i),
        .prio_o      (prio_o),
        .boost_o     (boost_o),
        .boost_idx_o (boost_idx_o),
        .boost_cnt_o (boost_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_cnt;
    logic [15:0] m_lfsr;
    int          m_wait [N];
    bit          m_boost;
    int          m_idx;
    int          m_bcnt;

    function automatic logic [15:0] lfsr_next(input logic [15:0] q);
        return (q >> 1) ^ (q[0] ? 16'hB400 : 16'h0000);
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin : model
        int  sel;
        bit  adv;
        if (!rst_ni) begin
            m_cnt   = 0;
            m_lfsr  = 16'hACE1;
            m_boost = 0;
            m_idx   = 0;
            m_bcnt  = 0;
            for (int i = 0; i < N; i++) m_wait[i] = 0;
        end else begin
            sel = -1;
            for (int i = 0; i < N; i++)
                if (sel < 0 && en_i && req_i[i] && !gnt_i[i] && m_wait[i] == THR) sel = i;
            adv = en_i && ((req_i & gnt_i) != 0);
            if (!m_boost) begin
                if (sel >= 0) begin
                    m_boost = 1;
                    m_idx   = sel;
                    if (m_bcnt < 65535) m_bcnt++;
                end
            end else if (!en_i || gnt_i[m_idx] || !req_i[m_idx]) begin
                m_boost = 0;
            end
            for (int i = 0; i < N; i++)
                m_wait[i] = (en_i && req_i[i] && !gnt_i[i]) ? ((m_wait[i] < THR) ? m_wait[i] + 1 : THR) : 0;
            if (adv) begin
                m_cnt  = (m_cnt + 1) % 8;
                m_lfsr = lfsr_next(m_lfsr);
            end
        end
    end

    always @(negedge clk_i) begin : compare
        int exp_prio;
        if (rst_ni) begin
            if (m_boost)     exp_prio = m_idx;
            else if (mode_i) exp_prio = int'(m_lfsr[2:0]);
            else             exp_prio = m_cnt;
            check("model_prio",      32'(prio_o),      32'(exp_prio));
            check("model_boost",     32'(boost_o),     32'(m_boost));
            check("model_boost_idx", 32'(boost_idx_o), m_boost ? 32'(m_idx) : 32'(boost_idx_o === 3'bx ? 0 : boost_idx_o));
            check("model_boost_cnt", 32'(boost_cnt_o), 32'(m_bcnt));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input logic en, input logic mode, input logic [N-1:0] req, input logic [N-1:0] gnt);
        en_i   = en;
        mode_i = mode;
        req_i  = req;
        gnt_i  = gnt;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset(input logic mode);
        rst_ni = 1'b0;
        en_i   = 1'b1;
        mode_i = mode;
        req_i  = '0;
        gnt_i  = '0;
        @(posedge clk_i);
        @(posedge clk_i);
        #2 rst_ni = 1'b1;
        #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        en_i   = 1'b0;
        mode_i = 1'b0;
        req_i  = '0;
        gnt_i  = '0;

        // Reset values and counter stepping.
        do_reset(1'b0);
        check("rst_prio",      32'(prio_o),      32'd0);
        check("rst_boost",     32'(boost_o),     32'd0);
        check("rst_boost_idx", 32'(boost_idx_o), 32'd0);
        check("rst_boost_cnt", 32'(boost_cnt_o), 32'd0);
        for (int k = 1; k <= 9; k++) begin
            cyc(1'b1, 1'b0, 8'hFF, 8'hFF);
            check("cnt_step", 32'(prio_o), 32'(k % 8));
        end

        // LFSR mode: ACE1 -> E270.
        do_reset(1'b1);
        check("lfsr_rst", 32'(prio_o), 32'd1);
        cyc(1'b1, 1'b1, 8'h01, 8'h01);
        check("lfsr_step", 32'(prio_o), 32'd0);
        cyc(1'b1, 1'b1, 8'h02, 8'h00);
        check("lfsr_hold", 32'(prio_o), 32'd0);

        // Single starving initiator.
        do_reset(1'b0);
        repeat (THR) cyc(1'b1, 1'b0, 8'h20, 8'h00);
        check("pre_boost", 32'(boost_o), 32'd0);
        cyc(1'b1, 1'b0, 8'h20, 8'h00);
        check("boost_on",  32'(boost_o),     32'd1);
        check("boost_idx", 32'(boost_idx_o), 32'd5);
        check("boost_prio",32'(prio_o),      32'd5);
        check("boost_cnt", 32'(boost_cnt_o), 32'd1);
        cyc(1'b1, 1'b0, 8'h20, 8'h20);
        check("boost_exit",      32'(boost_o), 32'd0);
        check("boost_exit_prio", 32'(prio_o),  32'd1);

        // Two starving initiators: lowest index first, then the other.
        do_reset(1'b0);
        repeat (THR + 1) cyc(1'b1, 1'b0, 8'h44, 8'h00);
        check("two_first_idx", 32'(boost_idx_o), 32'd2);
        check("two_first_on",  32'(boost_o),     32'd1);
        cyc(1'b1, 1'b0, 8'h44, 8'h04);
        check("two_gap", 32'(boost_o), 32'd0);
        cyc(1'b1, 1'b0, 8'h44, 8'h00);
        check("two_second_on",   32'(boost_o),     32'd1);
        check("two_second_prio", 32'(prio_o),      32'd6);
        check("two_second_cnt",  32'(boost_cnt_o), 32'd2);

        // Grant exactly on the threshold cycle blocks the boost.
        do_reset(1'b0);
        repeat (THR) cyc(1'b1, 1'b0, 8'h20, 8'h00);
        cyc(1'b1, 1'b0, 8'h20, 8'h20);
        check("thr_gnt_boost", 32'(boost_o),     32'd0);
        check("thr_gnt_cnt",   32'(boost_cnt_o), 32'd0);
        repeat (THR) cyc(1'b1, 1'b0, 8'h20, 8'h00);
        check("thr_gnt_wait_cleared", 32'(boost_o), 32'd0);
        cyc(1'b1, 1'b0, 8'h20, 8'h00);
        check("thr_gnt_reboost", 32'(boost_o), 32'd1);

        // Disable mid-boost.
        do_reset(1'b0);
        repeat (THR + 1) cyc(1'b1, 1'b0, 8'h20, 8'h00);
        check("dis_pre_boost", 32'(boost_o), 32'd1);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b0, 8'hFF, 8'hDF);
            check("dis_boost", 32'(boost_o), 32'd0);
            check("dis_prio",  32'(prio_o),  32'd0);
        end
        repeat (THR) cyc(1'b1, 1'b0, 8'h20, 8'h00);
        check("dis_wait_cleared", 32'(boost_o), 32'd0);
        cyc(1'b1, 1'b0, 8'h20, 8'h00);
        check("dis_reboost", 32'(boost_o), 32'd1);
        cyc(1'b1, 1'b0, 8'h20, 8'h20);
        check("dis_resume_prio", 32'(prio_o), 32'd1);

        // Randomized traffic, checked every cycle by the model comparison.
        do_reset(1'b0);
        for (int k = 0; k < 3000; k++) begin
            logic         en;
            logic         mode;
            logic [N-1:0] req;
            logic [N-1:0] gnt;
            en   = ($urandom_range(0, 19) != 0);
            mode = (k / 200) % 2 == 1 ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 9) == 0);
            req  = N'($urandom);
            if ($urandom_range(0, 3) == 0) gnt = req & N'($urandom);
            else                           gnt = req & N'($urandom) & N'($urandom) & N'($urandom);
            cyc(en, mode, req, gnt);
        end

        // Asynchronous reset mid-operation.
        repeat (THR + 1) cyc(1'b1, 1'b0, 8'h10, 8'h00);
        #2 rst_ni = 1'b0;
        #1;
        check("async_rst_boost", 32'(boost_o),     32'd0);
        check("async_rst_cnt",   32'(boost_cnt_o), 32'd0);
        check("async_rst_prio",  32'(prio_o),      32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tcdm_bfly_prio_ctrl.md
# tcdm_bfly_prio_ctrl

Priority scheduler for the radix-2 butterfly TCDM interconnect. It drives one priority bit per butterfly layer, shared by all routers of that layer. Base priorities come from a free-running round-robin counter or an LFSR, selected at run time. A starvation monitor temporarily forces the layer priorities in favour of any initiator that has waited too long. It sits next to the butterfly network, observing initiator-side req/gnt and feeding the routers' prio inputs.

## Interface
- NumIn, 8: number of initiator ports; power of two, 2..65536.
- NumLayers, $clog2(NumIn): butterfly layers and prio_o width; derived, not overridable.
- StarveThr, 15: stall cycles before boost; 1..255.
- LfsrSeed, 16'hACE1: LFSR reset value; must be non-zero.
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- en_i  in  1  scheduler enable.
- mode_i  in  1  0: round-robin counter, 1: LFSR.
- req_i  in  NumIn  initiator requests (network inputs).
- gnt_i  in  NumIn  grants returned to initiators.
- prio_o  out  NumLayers  priority bit per layer; bit l drives every router in layer l.
- boost_o  out  1  starvation boost active.
- boost_idx_o  out  $clog2(NumIn)  initiator currently boosted.
- boost_cnt_o  out  16  saturating count of boost entries.

## Operation
- Definitions:
  - Advance condition: adv = en_i & |(req_i & gnt_i).
  - Network convention: at layer l, initiator i's request enters router input i[l].
- Counter mode:
  - cnt_q is NumLayers bits, +1 on adv, wraps modulo 2^NumLayers.
  - base = cnt_q.
- LFSR mode:
  - 16-bit Galois LFSR, advances on adv: next = (q>>1) ^ (q[0] ? 16'hB400 : 0).
  - base = lfsr_q[NumLayers-1:0].
  - For NumLayers>16, base is lfsr_q zero-extended.
- Register behaviour across modes:
  - Both cnt_q and lfsr_q advance on adv regardless of mode_i.
  - mode_i selects base combinationally, so a mode switch takes effect in the same cycle.
- Wait counters: one per initiator, wait_q[i], 8 bits.
  - When en_i & req_i[i] & ~gnt_i[i]: wait_q[i] +1, saturating at StarveThr.
  - Otherwise: cleared to 0.
- FSM states: IDLE, BOOST.
  - IDLE -> BOOST when en_i and some i has wait_q[i]==StarveThr & req_i[i] & ~gnt_i[i].
  - On that transition: boost_idx_q = lowest such i, boost_cnt_o +1 (saturating at 16'hFFFF).
  - BOOST -> IDLE when gnt_i[boost_idx_q], or ~req_i[boost_idx_q], or ~en_i.
  - BOOST has no timeout.
- prio_o:
  - IDLE: prio_o = base.
  - BOOST: prio_o[l] = boost_idx_q[l], which selects the boosted initiator's input at every layer.
- en_i=0 freezes cnt_q and lfsr_q, clears all wait_q, and forces IDLE at the next edge. prio_o keeps showing base.
- Contention: while boosted, other initiators keep accumulating wait_q (saturated). When the FSM returns to IDLE, the next boost may start on the following edge.

## Timing
- Reset values:
  - cnt_q=0, lfsr_q=LfsrSeed, all wait_q=0, state IDLE, boost_idx_q=0, boost_cnt_o=0.
  - Hence prio_o = 0 in counter mode, LfsrSeed[NumLayers-1:0] in LFSR mode.
  - boost_o=0, boost_idx_o=0.
- All state is sampled on the rising edge. prio_o, boost_o and boost_idx_o depend only on flops plus mode_i.
- Latency:
  - A grant advances base one cycle later.
  - Stall cycles: a request stalled on edges 1..StarveThr reaches wait_q==StarveThr after edge StarveThr.
  - Boost entry: boost_o=1 and the forced prio_o appear after edge StarveThr+1 if the request is still stalled.
  - Boost exit: on the edge that samples gnt_i[boost_idx_q]=1; prio_o returns to base in the following cycle.
- Saturating wait_q never wraps. A grant in the same cycle as threshold detection blocks boost entry.
- Reset asserted mid-boost returns all state to reset values asynchronously.

## Test plan
- Reset, then counter mode, NumIn=8: prio_o=3'b000 and boost_o=0. Hold req_i=gnt_i=8'hFF for 9 cycles: prio_o steps 0,1,…,7,0.
- LFSR mode from reset, one granted cycle: lfsr_q goes 16'hACE1 -> 16'hE270, so prio_o goes 3'b001 -> 3'b000. A cycle with no grant leaves prio_o unchanged.
- StarveThr=3, req_i[5]=1 and gnt_i[5]=0 held:
  - After edge 4: boost_o=1, boost_idx_o=5, prio_o=3'b101, boost_cnt_o=1.
  - Pulse gnt_i[5]=1: the next cycle shows boost_o=0 and prio_o=base.
- StarveThr=3, initiators 2 and 6 starving together: initiator 2 is boosted first. After it is granted, initiator 6 is boosted on the next edge with prio_o=3'b110, and boost_cnt_o=2.
- Starving initiator granted exactly on the threshold cycle (wait_q=3, gnt=1): no boost occurs, boost_cnt_o stays 0, and wait_q returns to 0.
- Drop en_i mid-boost: next cycle boost_o=0, wait_q all 0, prio_o frozen across 5 granted cycles. Re-asserting en_i resumes counting from the held value.
